// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle MIPS-subset control path.
// Holds opcode/funct constants, ALU op codes, the sequencer state encoding,
// the per-cycle control bundle, and the DECODE dispatch helper.
package cpu_defs;

  // Opcode field values (instruction bits 31:26)
  localparam logic [5:0] OP_FUNCT = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Funct field values (instruction bits 5:0) for opcode 0
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_SLT = 3'd3,
    ALU_CNE = 3'd4
  } alu_op_t;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXEC   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_JAL      = 4'd10,
    ST_JR       = 4'd11,
    ST_I_EXEC   = 4'd12,
    ST_I_WB     = 4'd13,
    ST_ILL_E    = 4'd14,
    ST_ILL_F    = 4'd15
  } state_t;

  // Everything the sequencer drives into the datapath in one cycle.
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       jump_and_link;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
    logic       instr_done;
  } ctrl_t;

  // Opcode dispatch out of DECODE. Unsupported opcodes map back to FETCH;
  // the caller flags instr_done for that case.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_LW, OP_SW:     nxt = ST_MEM_ADDR;
      OP_FUNCT:         nxt = ST_R_EXEC;
      OP_BNE:           nxt = ST_BRANCH;
      OP_J:             nxt = ST_JUMP;
      OP_JAL:           nxt = ST_JAL;
      OP_ADDI, OP_XORI: nxt = ST_I_EXEC;
      default:          nxt = ST_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bus between the multi-cycle sequencer and the datapath.
// Inputs to control: op_code, func (from IR), mem_ready (memory handshake).
// Outputs from control: PC/IR/memory/regfile/ALU enables and selects, instr_done, state.
interface multicycle_control_if;
  logic [5:0] op_code;
  logic [5:0] func;
  logic       mem_ready;

  logic       pc_write;
  logic       branch;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       jump_and_link;
  logic       ALU_src_a;
  logic [1:0] ALU_src_b;
  logic [2:0] ALU_op;
  logic       instr_done;
  logic [3:0] state;

  // Controller side
  modport master (
    input  op_code, func, mem_ready,
    output pc_write, branch, pc_source, i_or_d, ir_write, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, jump_and_link, ALU_src_a, ALU_src_b,
           ALU_op, instr_done, state
  );

  // Datapath side
  modport slave (
    output op_code, func, mem_ready,
    input  pc_write, branch, pc_source, i_or_d, ir_write, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, jump_and_link, ALU_src_a, ALU_src_b,
           ALU_op, instr_done, state
  );
endinterface

// File: rtl/alu_func_decode.sv
// R-type funct decoder: maps func to an ALU op, flags JR, flags supported funct.
// Purely combinational, zero latency; no handshake.
// Ports: func in (6), alu_op out (ADD for JR/unknown), is_jr out, known out.
module alu_func_decode
  import cpu_defs::*;
(
  input  logic [5:0] func,
  output alu_op_t    alu_op,
  output logic       is_jr,
  output logic       known
);

  always_comb begin
    alu_op = ALU_ADD;
    is_jr  = 1'b0;
    known  = 1'b1;
    case (func)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_SLT:  alu_op = ALU_SLT;
      FN_JR:   is_jr  = 1'b1;
      default: known  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB control.
// Latency: 3-5 cycles per instruction (FETCH through instr_done), plus stall cycles.
// Backpressure: holds FETCH/MEM_RD/MEM_WR with strobes asserted until mem_ready.
// Ports: clk, reset (sync, active-high); bus = multicycle_control_if.master.
module multicycle_control
  import cpu_defs::*;
(
  input  logic                  clk,
  input  logic                  reset,
  multicycle_control_if.master  bus
);

  state_t  state_q, state_d;
  // op_code is only looked at in DECODE, so the two later decisions that
  // depend on it (LW vs SW, ADDI vs XORI) are captured there.
  logic    is_store_q, is_store_d;
  logic    is_xor_q, is_xor_d;
  ctrl_t   ctl, ctl_out;

  alu_op_t fn_alu_op;
  logic    fn_is_jr;
  logic    fn_known;

  alu_func_decode u_func_decode (
    .func   (bus.func),
    .alu_op (fn_alu_op),
    .is_jr  (fn_is_jr),
    .known  (fn_known)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      is_store_q <= 1'b0;
      is_xor_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      is_xor_q   <= is_xor_d;
    end
  end

  always_comb begin
    ctl        = '0;
    state_d    = state_q;
    is_store_d = is_store_q;
    is_xor_d   = is_xor_q;

    case (state_q)
      ST_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'd1;
        if (bus.mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // ALU forms PC + (imm << 2) speculatively for BNE.
        ctl.alu_src_b = 2'd3;
        is_store_d    = (bus.op_code == OP_SW);
        is_xor_d      = (bus.op_code == OP_XORI);
        state_d       = decode_next(bus.op_code);
        if (decode_next(bus.op_code) == ST_FETCH) begin
          ctl.instr_done = 1'b1;
        end
      end

      ST_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'd2;
        state_d       = is_store_q ? ST_MEM_WR : ST_MEM_RD;
      end

      ST_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
        if (bus.mem_ready) state_d = ST_MEM_WB;
      end

      ST_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = ST_FETCH;
      end

      ST_MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          ctl.instr_done = 1'b1;
          state_d        = ST_FETCH;
        end
      end

      ST_R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = fn_alu_op;
        if (fn_is_jr) begin
          state_d = ST_JR;
        end else if (!fn_known) begin
          ctl.instr_done = 1'b1;
          state_d        = ST_FETCH;
        end else begin
          state_d = ST_R_WB;
        end
      end

      ST_R_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = ST_FETCH;
      end

      ST_BRANCH: begin
        ctl.alu_src_a  = 1'b1;
        ctl.alu_op     = ALU_CNE;
        ctl.branch     = 1'b1;
        ctl.pc_source  = 2'd1;
        ctl.instr_done = 1'b1;
        state_d        = ST_FETCH;
      end

      ST_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = 2'd2;
        ctl.instr_done = 1'b1;
        state_d        = ST_FETCH;
      end

      ST_JAL: begin
        ctl.pc_write      = 1'b1;
        ctl.pc_source     = 2'd2;
        ctl.reg_write     = 1'b1;
        ctl.jump_and_link = 1'b1;
        ctl.instr_done    = 1'b1;
        state_d           = ST_FETCH;
      end

      ST_JR: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = 2'd3;
        ctl.instr_done = 1'b1;
        state_d        = ST_FETCH;
      end

      ST_I_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'd2;
        ctl.alu_op    = is_xor_q ? ALU_XOR : ALU_ADD;
        state_d       = ST_I_WB;
      end

      ST_I_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = ST_FETCH;
      end

      // 14 and 15 are unreachable encodings; recover silently.
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Reset masks every output, so an abandoned instruction cannot emit strobes.
  always_comb begin
    ctl_out = reset ? '0 : ctl;
  end

  assign bus.pc_write      = ctl_out.pc_write;
  assign bus.branch        = ctl_out.branch;
  assign bus.pc_source     = ctl_out.pc_source;
  assign bus.i_or_d        = ctl_out.i_or_d;
  assign bus.ir_write      = ctl_out.ir_write;
  assign bus.mem_read      = ctl_out.mem_read;
  assign bus.mem_write     = ctl_out.mem_write;
  assign bus.reg_write     = ctl_out.reg_write;
  assign bus.reg_dst       = ctl_out.reg_dst;
  assign bus.mem_to_reg    = ctl_out.mem_to_reg;
  assign bus.jump_and_link = ctl_out.jump_and_link;
  assign bus.ALU_src_a     = ctl_out.alu_src_a;
  assign bus.ALU_src_b     = ctl_out.alu_src_b;
  assign bus.ALU_op        = ctl_out.alu_op;
  assign bus.instr_done    = ctl_out.instr_done;
  assign bus.state         = reset ? 4'd0 : state_q;

endmodule
